obstacle_sweep: RTL



---
 rtl/physics_pkg.sv | 28 ++
 rtl/sat_resize.sv | 26 ++
 rtl/obstacle_sweep.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/physics_pkg.sv
// Shared types and default widths for the obstacle sweep sequencer.
// The accumulator reduction mode is selected by SWEEP_SATURATE_EN (see sat_resize).
package physics_pkg;

  localparam int POS_W_D   = 8;
  localparam int VEL_W_D   = 8;
  localparam int ACC_W_D   = 8;
  localparam int NVERT_D   = 5;
  localparam int NOBS_D    = 4;
  localparam int CNT_W_D   = $clog2(NOBS_D) + 1;
  localparam int ADDR_W_D  = $clog2(NOBS_D);
  localparam int NV_W_D    = $clog2(NVERT_D) + 1;
  localparam int ACC_EXT_D = ACC_W_D + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_LAUNCH,
    S_WAIT_CHK,
    S_ACCUM,
    S_DONE
  } sweep_state_t;

  // [0] = vertex x coordinates, [1] = vertex y coordinates
  typedef logic [1:0][NVERT_D-1:0][POS_W_D-1:0] vertex_arr_t;

endpackage

// File: rtl/sat_resize.sv
// Combinational signed width reduction: clamps when SWEEP_SATURATE_EN is
// defined, otherwise keeps the low OUT_W bits (two's-complement wrap).
module sat_resize #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

`ifdef SWEEP_SATURATE_EN
  localparam logic signed [IN_W-1:0] MAXV = IN_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W-1:0] MINV = ~MAXV;

  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAXV)      dout = MAXV[OUT_W-1:0];
    else if (din < MINV) dout = MINV[OUT_W-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^din[IN_W-1:OUT_W];
  always_comb dout = din[OUT_W-1:0];
`endif

endmodule

// File: rtl/obstacle_sweep.sv
// Walks the obstacle list for one car point, running the collision checker per
// obstacle and chaining its post-collision state. Macro: SWEEP_SATURATE_EN.
module obstacle_sweep
  import physics_pkg::*;
#(
  parameter int POSITION_SIZE     = 8,
  parameter int VELOCITY_SIZE     = 8,
  parameter int ACCELERATION_SIZE = 8,
  parameter int NUM_VERTICES      = 5,
  parameter int NUM_OBSTACLES     = 4
) (
  input  logic                                                clk_in,
  input  logic                                                rst_in,
  input  logic                                                begin_in,
  input  logic [$clog2(NUM_OBSTACLES):0]                      num_obstacles_in,
  input  logic signed [POSITION_SIZE-1:0]                     pos_x_in,
  input  logic signed [POSITION_SIZE-1:0]                     pos_y_in,
  input  logic signed [VELOCITY_SIZE-1:0]                     vel_x_in,
  input  logic signed [VELOCITY_SIZE-1:0]                     vel_y_in,
  input  logic signed [POSITION_SIZE-1:0]                     dx_in,
  input  logic signed [POSITION_SIZE-1:0]                     dy_in,
  output logic                                                obs_rd_out,
  output logic [$clog2(NUM_OBSTACLES)-1:0]                    obs_addr_out,
  input  logic                                                obs_valid_in,
  input  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]     obs_data_in,
  input  logic [$clog2(NUM_VERTICES):0]                       obs_nverts_in,
  output logic                                                chk_begin_out,
  output logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0]     chk_obstacle_out,
  output logic [$clog2(NUM_VERTICES):0]                       chk_num_vertices_out,
  output logic signed [POSITION_SIZE-1:0]                     chk_pos_x_out,
  output logic signed [POSITION_SIZE-1:0]                     chk_pos_y_out,
  output logic signed [VELOCITY_SIZE-1:0]                     chk_vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0]                     chk_vel_y_out,
  output logic signed [POSITION_SIZE-1:0]                     chk_dx_out,
  output logic signed [POSITION_SIZE-1:0]                     chk_dy_out,
  input  logic                                                chk_result_in,
  input  logic                                                chk_was_collision_in,
  input  logic signed [POSITION_SIZE-1:0]                     chk_x_new_in,
  input  logic signed [POSITION_SIZE-1:0]                     chk_y_new_in,
  input  logic signed [VELOCITY_SIZE-1:0]                     chk_vel_x_new_in,
  input  logic signed [VELOCITY_SIZE-1:0]                     chk_vel_y_new_in,
  input  logic signed [POSITION_SIZE-1:0]                     chk_x_int_in,
  input  logic signed [POSITION_SIZE-1:0]                     chk_y_int_in,
  input  logic signed [ACCELERATION_SIZE-1:0]                 chk_acc_x_in,
  input  logic signed [ACCELERATION_SIZE-1:0]                 chk_acc_y_in,
  output logic                                                busy_out,
  output logic                                                done_out,
  output logic signed [POSITION_SIZE-1:0]                     x_out,
  output logic signed [POSITION_SIZE-1:0]                     y_out,
  output logic signed [VELOCITY_SIZE-1:0]                     vel_x_out,
  output logic signed [VELOCITY_SIZE-1:0]                     vel_y_out,
  output logic signed [ACCELERATION_SIZE-1:0]                 acc_x_out,
  output logic signed [ACCELERATION_SIZE-1:0]                 acc_y_out,
  output logic [$clog2(NUM_OBSTACLES):0]                      hit_count_out
);

  localparam int CW = $clog2(NUM_OBSTACLES) + 1;
  localparam int AW = $clog2(NUM_OBSTACLES);
  localparam int NW = $clog2(NUM_VERTICES) + 1;
  localparam int AE = ACCELERATION_SIZE + 2;

  sweep_state_t state, next_state;

  logic [CW-1:0] idx, count, hits;
  logic signed [POSITION_SIZE-1:0] cur_px, cur_py, cur_dx, cur_dy, fin_x, fin_y;
  logic signed [VELOCITY_SIZE-1:0] cur_vx, cur_vy;
  logic signed [AE-1:0] acc_x, acc_y;
  logic signed [ACCELERATION_SIZE-1:0] acc_x_red, acc_y_red;
  logic [1:0][NUM_VERTICES-1:0][POSITION_SIZE-1:0] verts;
  logic [NW-1:0] nverts;

  // Checker results are latched on the done pulse; ACCUM uses the copies.
  logic res_hit;
  logic signed [POSITION_SIZE-1:0] res_xn, res_yn, res_xi, res_yi;
  logic signed [VELOCITY_SIZE-1:0] res_vx, res_vy;
  logic signed [ACCELERATION_SIZE-1:0] res_ax, res_ay;

  logic start, done_r, busy_r;
  assign start = (state == S_IDLE) && begin_in && !busy_r;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start) next_state = (num_obstacles_in == '0) ? S_DONE : S_FETCH;
      S_FETCH:    next_state = S_WAIT_MEM;
      S_WAIT_MEM: if (obs_valid_in)
                    next_state = (obs_nverts_in < NW'(2)) ? S_ACCUM : S_LAUNCH;
      S_LAUNCH:   next_state = S_WAIT_CHK;
      S_WAIT_CHK: if (chk_result_in) next_state = S_ACCUM;
      S_ACCUM:    next_state = (idx + CW'(1) == count) ? S_DONE : S_FETCH;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    obs_rd_out    = (state == S_FETCH);
    chk_begin_out = (state == S_LAUNCH);
  end

  assign obs_addr_out         = idx[AW-1:0];
  assign chk_obstacle_out     = verts;
  assign chk_num_vertices_out = nverts;
  assign chk_pos_x_out        = cur_px;
  assign chk_pos_y_out        = cur_py;
  assign chk_vel_x_out        = cur_vx;
  assign chk_vel_y_out        = cur_vy;
  assign chk_dx_out           = cur_dx;
  assign chk_dy_out           = cur_dy;
  assign busy_out             = busy_r;
  assign done_out             = done_r;

  sat_resize #(.IN_W(AE), .OUT_W(ACCELERATION_SIZE)) u_sat_x (.din(acc_x), .dout(acc_x_red));
  sat_resize #(.IN_W(AE), .OUT_W(ACCELERATION_SIZE)) u_sat_y (.din(acc_y), .dout(acc_y_red));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx <= '0; count <= '0; hits <= '0;
      cur_px <= '0; cur_py <= '0; cur_dx <= '0; cur_dy <= '0;
      cur_vx <= '0; cur_vy <= '0; fin_x <= '0; fin_y <= '0;
      acc_x <= '0; acc_y <= '0; verts <= '0; nverts <= '0;
      res_hit <= 1'b0; res_xn <= '0; res_yn <= '0; res_xi <= '0; res_yi <= '0;
      res_vx <= '0; res_vy <= '0; res_ax <= '0; res_ay <= '0;
      done_r <= 1'b0; busy_r <= 1'b0;
      x_out <= '0; y_out <= '0; vel_x_out <= '0; vel_y_out <= '0;
      acc_x_out <= '0; acc_y_out <= '0; hit_count_out <= '0;
    end else begin
      done_r <= (state == S_DONE);
      if (start)       busy_r <= 1'b1;
      else if (done_r) busy_r <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          cur_px <= pos_x_in; cur_py <= pos_y_in;
          cur_vx <= vel_x_in; cur_vy <= vel_y_in;
          cur_dx <= dx_in;    cur_dy <= dy_in;
          acc_x <= '0; acc_y <= '0; hits <= '0; idx <= '0;
          count <= (num_obstacles_in > CW'(NUM_OBSTACLES)) ? CW'(NUM_OBSTACLES)
                                                           : num_obstacles_in;
        end
        S_WAIT_MEM: if (obs_valid_in) begin
          verts  <= obs_data_in;
          nverts <= obs_nverts_in;
          if (obs_nverts_in < NW'(2)) res_hit <= 1'b0;
        end
        S_WAIT_CHK: if (chk_result_in) begin
          res_hit <= chk_was_collision_in;
          res_xn <= chk_x_new_in;     res_yn <= chk_y_new_in;
          res_xi <= chk_x_int_in;     res_yi <= chk_y_int_in;
          res_vx <= chk_vel_x_new_in; res_vy <= chk_vel_y_new_in;
          res_ax <= chk_acc_x_in;     res_ay <= chk_acc_y_in;
        end
        S_ACCUM: begin
          if (res_hit) begin
            acc_x  <= acc_x + {{2{res_ax[ACCELERATION_SIZE-1]}}, res_ax};
            acc_y  <= acc_y + {{2{res_ay[ACCELERATION_SIZE-1]}}, res_ay};
            hits   <= hits + CW'(1);
            cur_px <= res_xi; cur_py <= res_yi;
            cur_vx <= res_vx; cur_vy <= res_vy;
            cur_dx <= res_xn - res_xi;
            cur_dy <= res_yn - res_yi;
            fin_x  <= res_xn; fin_y <= res_yn;
          end
          idx <= idx + CW'(1);
        end
        S_DONE: begin
          // Without a hit the working point is still the start point.
          x_out <= (hits == '0) ? cur_px + cur_dx : fin_x;
          y_out <= (hits == '0) ? cur_py + cur_dy : fin_y;
          vel_x_out <= cur_vx; vel_y_out <= cur_vy;
          acc_x_out <= acc_x_red; acc_y_out <= acc_y_red;
          hit_count_out <= hits;
        end
        default: ;
      endcase
    end
  end

endmodule
